// File: rtl/load_extend_unit.sv
// load_extend_unit: memory-stage load formatter.
// Selects the addressed byte/half/word/dword lane of a raw memory word,
// sign- or zero-extends it to DATA_W, flags misaligned or illegal-size
// accesses, and queues results in a 2-entry valid/ready buffer so that a
// stalled consumer never loses a load. Output registers are the buffer head.
module load_extend_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count
);

  // Buffer occupancy doubles as the control state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  buf_state_t state_reg;
  buf_state_t state_next;

  // Head entry drives the outputs; tail holds the second queued entry.
  logic [DATA_W-1:0] head_data_reg;
  logic [TAG_W-1:0]  head_tag_reg;
  logic              head_err_reg;
  logic [DATA_W-1:0] tail_data_reg;
  logic [TAG_W-1:0]  tail_tag_reg;
  logic              tail_err_reg;
  logic [CNT_W-1:0]  err_count_reg;

  logic load_head_new;
  logic load_head_tail;
  logic load_tail;
  logic push;
  logic pop;

  // Extraction datapath
  logic [DATA_W-1:0]       lane;
  logic [3:0][DATA_W-1:0]  ext;
  logic [3:0]              size_legal;
  logic [3:0]              low_mask;
  logic [3:0]              off_ext;
  logic                    misaligned;
  logic                    illegal;
  logic                    load_err;
  logic [DATA_W-1:0]       load_data;

  // Shift the addressed byte down to bit 0.
  assign lane = in_word >> {in_offset, 3'b000};

  // One candidate result per access size. Sizes wider than the datapath are
  // never selected (they are flagged illegal), and the full-width size has
  // nothing to extend, so in_signed is irrelevant there.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_size
      localparam int LW = 8 << gi;
      if (LW < DATA_W) begin : g_part
        assign ext[gi]        = {{(DATA_W - LW){in_signed & lane[LW-1]}}, lane[LW-1:0]};
        assign size_legal[gi] = 1'b1;
      end else if (LW == DATA_W) begin : g_full
        assign ext[gi]        = lane;
        assign size_legal[gi] = 1'b1;
      end else begin : g_wide
        assign ext[gi]        = '0;
        assign size_legal[gi] = 1'b0;
      end
    end
  endgenerate

  // Offset bits that must be zero for a naturally aligned access of each size.
  always_comb begin
    low_mask = 4'b0000;
    case (in_size)
      2'd0:    low_mask = 4'b0000;
      2'd1:    low_mask = 4'b0001;
      2'd2:    low_mask = 4'b0011;
      default: low_mask = 4'b0111;
    endcase
  end

  assign off_ext    = 4'(in_offset);
  assign misaligned = |(off_ext & low_mask);
  assign illegal    = ~size_legal[in_size];
  assign load_err   = misaligned | illegal;
  assign load_data  = load_err ? '0 : ext[in_size];

  // Handshake: in_ready looks only at registered occupancy.
  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next occupancy and which buffer registers load this cycle.
  always_comb begin
    state_next     = state_reg;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next    = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          state_next = TWO;
          load_tail  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next     = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Head entry: new result or promoted tail; otherwise holds (including when empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_reg <= '0;
      head_tag_reg  <= '0;
      head_err_reg  <= 1'b0;
    end else if (load_head_new) begin
      head_data_reg <= load_data;
      head_tag_reg  <= in_tag;
      head_err_reg  <= load_err;
    end else if (load_head_tail) begin
      head_data_reg <= tail_data_reg;
      head_tag_reg  <= tail_tag_reg;
      head_err_reg  <= tail_err_reg;
    end
  end

  // Tail entry: captures a result pushed while the head is still waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_data_reg <= '0;
      tail_tag_reg  <= '0;
      tail_err_reg  <= 1'b0;
    end else if (load_tail) begin
      tail_data_reg <= load_data;
      tail_tag_reg  <= in_tag;
      tail_err_reg  <= load_err;
    end
  end

  // Saturating count of accepted loads that carried an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg <= '0;
    end else if (push && load_err && (err_count_reg != {CNT_W{1'b1}})) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign out_data  = head_data_reg;
  assign out_tag   = head_tag_reg;
  assign out_err   = head_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Memory-stage load formatter for the MIPS datapath.
- Takes a raw data-memory word, the byte offset, the access size and a signed/unsigned flag, and selects the addressed byte, halfword or word lane.
- Sign- or zero-extends that lane to DATA_W bits and flags misaligned or illegal accesses.
- Results pass through a 2-entry valid/ready buffer, so a stalled write-back stage never drops a load; replaces the fixed 8/16-bit extenders on the load path.

Parameters:
DATA_W, 32, datapath/memory word width in bits; legal values 32 or 64.
TAG_W, 5, width of the destination-register tag carried alongside each load.
CNT_W, 16, width of the saturating error counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  load request present
in_ready  output  1  unit can accept a request this cycle
in_word  input  DATA_W  raw word read from data memory
in_offset  input  log2(DATA_W/8)  byte address bits within the word
in_size  input  2  0=byte, 1=half, 2=word, 3=dword
in_signed  input  1  1=sign-extend, 0=zero-extend
in_tag  input  TAG_W  destination register number
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
out_data  output  DATA_W  extended load result
out_tag  output  TAG_W  tag of the result
out_err  output  1  access was misaligned or illegal size
err_count  output  CNT_W  number of errored loads accepted, saturating

Behaviour:
- Reset (async, rst=1):
  - Buffer count=0; out_valid=0, out_data=0, out_tag=0, out_err=0, err_count=0.
  - in_ready=1 as soon as count=0 is established.
- Push/pop:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2); depends only on registered state, with no combinational path from out_ready.
- Latency and throughput:
  - An accepted request appears on the outputs on the next rising edge.
  - Sustained throughput is 1 per cycle while out_ready=1.
- Extraction (combinational on input, result stored in buffer):
  - lane = in_word >> (8*in_offset).
  - Keep the low 8<<in_size bits.
  - Upper bits = copy of the lane MSB if in_signed, else 0.
  - For size equal to DATA_W, in_signed has no effect.
- Errors:
  - illegal = (8<<in_size) > DATA_W (size 3 is illegal when DATA_W=32).
  - misaligned = in_offset mod (1<<in_size) != 0.
  - err = illegal | misaligned. On err: stored data = 0, out_err=1, tag passed unchanged.
  - err_count increments on each push with err=1 and saturates at 2^CNT_W-1.
- Buffer states (count 0/1/2):
  - 0: push -> 1.
  - 1: push only -> 2; pop only -> 0; push+pop -> stays 1, new entry becomes head next cycle.
  - 2: pop -> 1, second entry becomes head; no push possible.
- Output hold: while out_valid=1 and out_ready=0, out_data/out_tag/out_err hold stable.
- out_valid = (count != 0). Outputs show the head entry; they keep their last value when count=0, except after reset (0).
- Order is strictly FIFO.
- Reset mid-operation: all buffered entries are discarded; no partial outputs after rst deasserts.

Test Plan:
- DATA_W=32, in_word=0x8081F2F3, offset=1, size=0, signed=1, tag=7 -> next cycle out_valid=1, out_data=0xFFFFFFF2, out_tag=7, out_err=0; same with signed=0 -> 0x000000F2.
- Halfword: in_word=0x8001_7FFF, offset=2, size=1, signed=1 -> 0xFFFF8001; offset=0 -> 0x00007FFF.
- Misaligned/illegal:
  - offset=1, size=1 -> out_err=1, out_data=0, err_count=1.
  - size=2, offset=3 -> err_count=2.
  - size=3 on DATA_W=32 -> out_err=1, err_count=3.
- Backpressure: out_ready=0, push A, B -> in_ready=0 after second push, out_data holds A; raise out_ready -> A then B on consecutive cycles, in_ready returns to 1.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with offsets 0..3 cycling -> 8 results in order, one per cycle, count never exceeds 1.
- Reset mid-operation: two entries buffered, assert rst asynchronously -> out_valid=0, err_count=0, in_ready=1 immediately; DATA_W=64 build, dword load signed=1 of 0xFFFF_0000_0000_0001 -> passed unchanged.
